sd_port_arbiter: RTL and testbench

//  Shares the single SD_SIM BRAM port (ena/wea/addra/dina/douta) among the cracker's requesters:

---
 rtl/vader_pkg.sv | 17 +
 rtl/rr_pick.sv | 33 +++
 rtl/sd_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sd_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vader_pkg.sv
// Shared constants for the cracker's SD_SIM BRAM access path: requester ids,
// BRAM geometry and the state encoding of the port arbiter.
package vader_pkg;

    localparam int REQ_HASH  = 0;
    localparam int REQ_DICT  = 1;
    localparam int REQ_BRUTE = 2;

    localparam int SD_AW = 8;
    localparam int SD_DW = 128;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: grants the first requester after i_rr_ptr
// (wrapping modulo NREQ) whose request is set and which is not excluded.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_rr_ptr,
    input  logic [NREQ-1:0] i_excl,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx
);

    logic          w_found;
    logic [PW-1:0] w_pos;

    // Scan rr_ptr+1, rr_ptr+2, ... and keep only the first eligible hit
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = PW'((int'(i_rr_ptr) + k) % NREQ);
            if (!w_found && i_req[w_pos] && !i_excl[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_port_arbiter.sv
// Shares the single SD_SIM BRAM port among the hash loader, dictionary reader
// and brute candidate engine. Round-robin grant with a bounded streaming lock,
// registered BRAM drive, and an id pipe that steers read data to its issuer.
module sd_port_arbiter
    import vader_pkg::*;
#(
    parameter int NREQ         = REQ_BRUTE + 1,
    parameter int AW           = SD_AW,
    parameter int DW           = SD_DW,
    parameter int READ_LATENCY = 1,
    parameter int MAX_LOCK     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               bram_ena,
    output logic               bram_wea,
    output logic [AW-1:0]      bram_addra,
    output logic [DW-1:0]      bram_dina,
    input  logic [DW-1:0]      bram_douta,
    output logic               busy
);

    localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            CW       = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);
    localparam logic [PW-1:0] PTR_INIT = PW'(NREQ - 1);

    arb_state_t    r_state, w_state_nxt;
    logic [PW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [PW-1:0] r_owner, w_owner_nxt;
    logic [CW-1:0] r_lock_cnt, w_lock_cnt_nxt;

    logic [NREQ-1:0] w_owner_hot, w_others, w_excl, w_pick_grant, w_grant;
    logic [PW-1:0]   w_pick_idx, w_win_idx;
    logic            w_hold, w_at_max, w_accept;

    logic          r_ena, r_wea;
    logic [AW-1:0] r_addra;
    logic [DW-1:0] r_dina;
    logic [PW-1:0] r_issue_id;

    logic [READ_LATENCY-1:0] r_pipe_valid;
    logic [PW-1:0]           r_pipe_id [READ_LATENCY];

    // The locked owner keeps the port until it stops asking or uses up its
    // budget; once exhausted it is masked out only if someone else is waiting.
    assign w_owner_hot = NREQ'(1) << r_owner;
    assign w_others    = req_valid & ~w_owner_hot;
    assign w_at_max    = (r_lock_cnt >= LOCK_MAX);
    assign w_hold      = (r_state == ST_LOCKED) && req_valid[r_owner] && !w_at_max;
    assign w_excl      = ((r_state == ST_LOCKED) && w_at_max && (|w_others)) ? w_owner_hot : '0;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .i_excl   (w_excl),
        .o_grant  (w_pick_grant),
        .o_idx    (w_pick_idx)
    );

    assign w_grant   = w_hold ? w_owner_hot : w_pick_grant;
    assign w_win_idx = w_hold ? r_owner : w_pick_idx;
    assign w_accept  = |w_grant;
    assign req_ready = w_grant;

    // Next arbitration state: lock bookkeeping and round-robin pointer update
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_hold) begin
            w_lock_cnt_nxt = r_lock_cnt + CW'(1);
            if (!req_lock[r_owner]) begin
                w_state_nxt = ST_ARB;
            end
        end else if (w_accept) begin
            w_rr_ptr_nxt = w_pick_idx;
            if (req_lock[w_pick_idx]) begin
                w_state_nxt    = ST_LOCKED;
                w_owner_nxt    = w_pick_idx;
                w_lock_cnt_nxt = CW'(1);
            end else begin
                w_state_nxt    = ST_ARB;
                w_lock_cnt_nxt = '0;
            end
        end else begin
            w_state_nxt    = ST_ARB;
            w_lock_cnt_nxt = '0;
        end
    end

    // Arbitration state register; requester 0 wins first out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= PTR_INIT;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Registered BRAM drive: one cycle of enable per accepted access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ena      <= 1'b0;
            r_wea      <= 1'b0;
            r_addra    <= '0;
            r_dina     <= '0;
            r_issue_id <= '0;
        end else begin
            r_ena <= w_accept;
            r_wea <= w_accept & req_we[w_win_idx];
            if (w_accept) begin
                r_addra    <= req_addr[int'(w_win_idx)*AW +: AW];
                r_dina     <= req_wdata[int'(w_win_idx)*DW +: DW];
                r_issue_id <= w_win_idx;
            end
        end
    end

    // Read id pipe tracking the BRAM latency; reset drops anything in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_valid <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_pipe_id[s] <= '0;
            end
        end else begin
            r_pipe_valid[0] <= r_ena & ~r_wea;
            r_pipe_id[0]    <= r_issue_id;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pipe_valid[s] <= r_pipe_valid[s-1];
                r_pipe_id[s]    <= r_pipe_id[s-1];
            end
        end
    end

    // Steer the read strobe to the issuer of the data now on douta
    always_comb begin
        rsp_valid = '0;
        if (r_pipe_valid[READ_LATENCY-1]) begin
            rsp_valid[r_pipe_id[READ_LATENCY-1]] = 1'b1;
        end
    end

    assign rsp_data   = bram_douta;
    assign bram_ena   = r_ena;
    assign bram_wea   = r_wea;
    assign bram_addra = r_addra;
    assign bram_dina  = r_dina;
    assign busy       = r_ena | (|r_pipe_valid);

endmodule

// File: tb/tb_sd_port_arbiter.sv
// Bench for sd_port_arbiter: a grant-order vector table, hand-written
// write/read and reset sequences, and random traffic checked every cycle
// against a behavioural model of the arbitration rules and the BRAM contents.
module tb_sd_port_arbiter;
    import vader_pkg::*;

    localparam int NREQ     = 3;
    localparam int MAX_LOCK = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   req_valid, req_we, req_lock;
    logic [23:0]  req_addr;
    logic [383:0] req_wdata;
    logic [2:0]   req_ready, rsp_valid;
    logic [127:0] rsp_data, bram_dina, bram_douta;
    logic         bram_ena, bram_wea, busy;
    logic [7:0]   bram_addra;

    typedef struct {
        logic [2:0] valid;
        logic [2:0] we;
        logic [2:0] lock;
        logic [2:0] expReady;
    } vec_t;

    typedef struct {
        int           due;
        int           id;
        logic [127:0] data;
    } rsp_t;

    vec_t vecs[$];
    rsp_t pend[$];

    logic [127:0] mem [256];
    bit           memWritten [256];
    logic [127:0] refMem [int];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit         mLocked;
    int         mOwner, mCnt, mLast;
    logic [2:0] seenReady;

    always #5 clk = ~clk;

    sd_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_douta (bram_douta),
        .busy       (busy)
    );

    function automatic logic [127:0] initPattern(input int a);
        return {4{32'hC0DE_0000 | 32'(a)}};
    endfunction

    // Single-port BRAM with one clock of read latency
    always @(posedge clk) begin
        if (bram_ena) begin
            if (bram_wea) begin
                mem[bram_addra]        <= bram_dina;
                memWritten[bram_addra] <= 1'b1;
            end else begin
                bram_douta <= memWritten[bram_addra] ? mem[bram_addra] : initPattern(int'(bram_addra));
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int pickRR(input logic [2:0] v, input int excl);
        int j;
        for (int k = 1; k <= NREQ; k++) begin
            j = (mLast + k) % NREQ;
            if (v[j] && j != excl) return j;
        end
        return -1;
    endfunction

    function automatic logic [383:0] randWide();
        logic [383:0] x;
        for (int k = 0; k < 12; k++) x[k*32 +: 32] = $urandom;
        return x;
    endfunction

    task automatic resetModel();
        mLocked = 1'b0;
        mOwner  = 0;
        mCnt    = 0;
        mLast   = NREQ - 1;
        pend.delete();
    endtask

    task automatic addVec(input logic [2:0] v, we, lk, exp, input int n);
        vec_t e;
        e.valid = v; e.we = we; e.lock = lk; e.expReady = exp;
        for (int i = 0; i < n; i++) vecs.push_back(e);
    endtask

    // One clock: drive inputs, predict the grant, then check the cycle after the edge
    task automatic applyStimulus(input logic [2:0] v, we, lk, input logic [23:0] addrs, input logic [383:0] wd);
        int           w;
        bit           held, expEna, expWea, rspDue;
        logic [2:0]   expReady;
        logic [7:0]   a;
        logic [127:0] d;
        rsp_t         r;
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        req_addr  = addrs;
        req_wdata = wd;
        #1;
        held = mLocked && v[mOwner] && (mCnt < MAX_LOCK);
        if (held) w = mOwner;
        else if (mLocked && mCnt >= MAX_LOCK && ((v & ~(3'b001 << mOwner)) != 3'b000)) w = pickRR(v, mOwner);
        else w = pickRR(v, -1);
        expReady  = (w >= 0) ? (3'b001 << w) : 3'b000;
        seenReady = req_ready;
        checkOutput("req_ready", req_ready, expReady);
        expEna = (w >= 0);
        expWea = 1'b0;
        a      = '0;
        d      = '0;
        if (w >= 0) begin
            a      = addrs[w*8 +: 8];
            d      = wd[w*128 +: 128];
            expWea = we[w];
            if (we[w]) begin
                refMem[int'(a)] = d;
            end else begin
                r.due  = cyc + 2;
                r.id   = w;
                r.data = refMem.exists(int'(a)) ? refMem[int'(a)] : initPattern(int'(a));
                pend.push_back(r);
            end
            mLast = w;
            if (held) begin
                mCnt++;
                if (!lk[w]) mLocked = 1'b0;
            end else if (lk[w]) begin
                mLocked = 1'b1;
                mOwner  = w;
                mCnt    = 1;
            end else begin
                mLocked = 1'b0;
                mCnt    = 0;
            end
        end else begin
            mLocked = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        checkOutput("bram_ena", bram_ena, expEna);
        if (expEna) begin
            checkOutput("bram_wea", bram_wea, expWea);
            checkOutput("bram_addra", bram_addra, a);
            if (expWea) checkOutput("bram_dina", bram_dina, d);
        end
        rspDue = (pend.size() > 0) && (pend[0].due == cyc);
        if (rspDue) begin
            r = pend.pop_front();
            checkOutput("rsp_valid", rsp_valid, 3'b001 << r.id);
            checkOutput("rsp_data", rsp_data, r.data);
        end else begin
            checkOutput("rsp_valid", rsp_valid, 3'b000);
        end
        checkOutput("busy", busy, expEna | rspDue);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(3'b000, 3'b000, 3'b000, 24'h0, '0);
    endtask

    task automatic runRandom(input int n);
        logic [2:0]  v, we, lk;
        logic [23:0] addrs;
        for (int i = 0; i < n; i++) begin
            v  = 3'($urandom_range(0, 7) | $urandom_range(0, 7));
            lk = 3'($urandom_range(0, 7) | $urandom_range(0, 7));
            we = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            for (int k = 0; k < 3; k++) addrs[k*8 +: 8] = 8'($urandom_range(0, 15));
            applyStimulus(v, we, lk, addrs, randWide());
        end
    endtask

    initial begin
        logic [127:0] dbeef;
        dbeef     = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        req_valid = 3'b000;
        req_we    = 3'b000;
        req_lock  = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        reset     = 1'b0;
        resetModel();

        // Reset state, including the pointer that makes requester 0 win first
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_bram_ena", bram_ena, 1'b0);
        checkOutput("rst_bram_wea", bram_wea, 1'b0);
        checkOutput("rst_bram_addra", bram_addra, 8'h00);
        checkOutput("rst_bram_dina", bram_dina, '0);
        checkOutput("rst_rsp_valid", rsp_valid, 3'b000);
        checkOutput("rst_busy", busy, 1'b0);
        req_valid = 3'b111;
        #1;
        checkOutput("rst_ready_all", req_ready, 3'b001);
        req_valid = 3'b000;
        #1;
        checkOutput("rst_ready_none", req_ready, 3'b000);
        @(negedge clk);
        reset = 1'b1;

        // Single read from the hash loader
        applyStimulus(3'b001, 3'b000, 3'b000, {8'h00, 8'h00, 8'h05}, '0);
        checkOutput("t1_ready", seenReady, 3'b001 << REQ_HASH);
        checkOutput("t1_addra", bram_addra, 8'h05);
        idle();
        checkOutput("t1_rsp_valid", rsp_valid, 3'b001 << REQ_HASH);
        checkOutput("t1_rsp_data", rsp_data, initPattern(5));

        // Grant-order table: round robin, lock budget, owner drop, release, only-owner restart
        addVec(3'b111, 3'b000, 3'b000, 3'b010, 1);
        addVec(3'b111, 3'b000, 3'b000, 3'b100, 1);
        addVec(3'b111, 3'b000, 3'b000, 3'b001, 1);
        addVec(3'b111, 3'b000, 3'b000, 3'b010, 1);
        addVec(3'b111, 3'b000, 3'b000, 3'b100, 1);
        addVec(3'b111, 3'b000, 3'b000, 3'b001, 1);
        addVec(3'b011, 3'b000, 3'b010, 3'b010, 8);
        addVec(3'b011, 3'b000, 3'b010, 3'b001, 1);
        addVec(3'b011, 3'b000, 3'b010, 3'b010, 1);
        addVec(3'b100, 3'b000, 3'b000, 3'b100, 1);
        addVec(3'b000, 3'b000, 3'b000, 3'b000, 1);
        addVec(3'b110, 3'b000, 3'b010, 3'b010, 1);
        addVec(3'b110, 3'b000, 3'b000, 3'b010, 1);
        addVec(3'b110, 3'b000, 3'b000, 3'b100, 1);
        addVec(3'b010, 3'b000, 3'b010, 3'b010, 9);
        addVec(3'b011, 3'b000, 3'b010, 3'b010, 7);
        addVec(3'b011, 3'b000, 3'b010, 3'b001, 1);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].we, vecs[i].lock,
                          {8'(3*i + 2), 8'(3*i + 1), 8'(3*i)}, randWide());
            checkOutput("tbl_ready", seenReady, vecs[i].expReady);
        end
        idle();

        // Write from the dictionary reader, then read-back by the brute engine
        applyStimulus(3'b010, 3'b010, 3'b000, {8'h00, 8'h03, 8'h00}, {128'h0, dbeef, 128'h0});
        checkOutput("t3_wr_ready", seenReady, 3'b001 << REQ_DICT);
        applyStimulus(3'b100, 3'b000, 3'b000, {8'h03, 8'h00, 8'h00}, '0);
        checkOutput("t3_no_wr_rsp", rsp_valid, 3'b000);
        idle();
        checkOutput("t3_rsp_valid", rsp_valid, 3'b001 << REQ_BRUTE);
        checkOutput("t3_rsp_data", rsp_data, dbeef);

        runRandom(400);
        idle();
        idle();

        // Reset while a read is in flight
        applyStimulus(3'b001, 3'b000, 3'b000, {8'h00, 8'h00, 8'h22}, '0);
        req_valid = 3'b000;
        reset     = 1'b0;
        #1;
        checkOutput("t6_ena_async", bram_ena, 1'b0);
        checkOutput("t6_addra_async", bram_addra, 8'h00);
        checkOutput("t6_busy_async", busy, 1'b0);
        checkOutput("t6_rsp_async", rsp_valid, 3'b000);
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle();
        idle();
        idle();
        applyStimulus(3'b111, 3'b000, 3'b000, {8'h01, 8'h02, 8'h03}, '0);
        checkOutput("t6_first_grant", seenReady, 3'b001 << REQ_HASH);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
